// File: rtl/mux_add_pkg.sv
// mux_add_pkg: shared constants for the stochastic scaled adder.
// Holds default stream counts, the maximal-length Fibonacci LFSR tap masks
// for widths 4..16 and the LFSR seed used by the optional internal select
// (enabled with MUX_ADD_LFSR_SEL_EN).
package mux_add_pkg;

    localparam int DEF_INUM    = 2;
    localparam int DEF_LOGINUM = 1;
    localparam int DEF_LFSR_W  = 8;

    localparam int LFSR_W_MIN = 4;
    localparam int LFSR_W_MAX = 16;

    typedef logic [LFSR_W_MAX-1:0] tap_mask_t;

    // Non-zero seed so the LFSR never locks up in the all-zero state.
    localparam tap_mask_t LFSR_SEED = 16'h0001;

    // Tap masks: bit k-1 set means stage k feeds the XOR.
    // The MSB stage is always tapped.
    function automatic tap_mask_t lfsr_taps(input int w);
        tap_mask_t m;
        case (w)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mux_add_sel_lfsr.sv
// mux_add_sel_lfsr: free-running Fibonacci LFSR that supplies a pseudo-random
// stream select. Only instantiated when MUX_ADD_LFSR_SEL_EN is defined.
module mux_add_sel_lfsr
    import mux_add_pkg::*;
#(
    parameter int LFSR_W = DEF_LFSR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] state
);

    if (LFSR_W < LFSR_W_MIN || LFSR_W > LFSR_W_MAX) begin : g_bad_width
        $error("mux_add_sel_lfsr: LFSR_W must be in 4..16");
    end

    localparam tap_mask_t       TAPS_FULL = lfsr_taps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS    = TAPS_FULL[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] SEED    = LFSR_SEED[LFSR_W-1:0];

    logic feedback;

    // XOR of the tapped stages is shifted in at the bottom.
    always_comb begin
        feedback = ^(state & TAPS);
    end

    // Advance every cycle; reset returns to the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= {state[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/mux_add.sv
// mux_add: registered multiplexer acting as a stochastic scaled adder.
// One of INUM bitstreams is selected each cycle and registered to out.
// Build option MUX_ADD_LFSR_SEL_EN: the select comes from an internal LFSR
// and the sel port is ignored; the port list is the same in both builds.
module mux_add
    import mux_add_pkg::*;
#(
    parameter int INUM    = DEF_INUM,
    parameter int LOGINUM = DEF_LOGINUM,
    parameter int LFSR_W  = DEF_LFSR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INUM-1:0]    in,
    input  logic [LOGINUM-1:0] sel,
    output logic               out
);

    if (LOGINUM < 1 || (1 << LOGINUM) != INUM) begin : g_bad_inum
        $error("mux_add: INUM must be a power of two >= 2 and LOGINUM = log2(INUM)");
    end

    if (LFSR_W < LOGINUM) begin : g_bad_lfsr_w
        $error("mux_add: LFSR_W must be >= LOGINUM");
    end

    logic [LOGINUM-1:0] sel_eff;

`ifdef MUX_ADD_LFSR_SEL_EN
    logic [LFSR_W-1:0] lfsr_state;
    logic              unused_sel;

    mux_add_sel_lfsr #(
        .LFSR_W (LFSR_W)
    ) u_sel_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr_state)
    );

    // The low LFSR bits before this edge's update pick the stream.
    always_comb begin
        sel_eff    = lfsr_state[LOGINUM-1:0];
        unused_sel = ^sel;
    end
`else
    // External select drives the mux directly.
    always_comb begin
        sel_eff = sel;
    end
`endif

    // Register the selected bit; only the selected input reaches out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 1'b0;
        end else begin
            out <= in[sel_eff];
        end
    end

endmodule

// File: tb/tb_mux_add.sv
// tb_mux_add: self-checking bench for mux_add (2-input and 4-input instances).
// Build option MUX_ADD_LFSR_SEL_EN selects the LFSR-select checks.
module tb_mux_add;

    logic       clk;
    logic       rst_n;
    logic [1:0] in2;
    logic [0:0] sel2;
    logic       out2;
    logic [3:0] in4;
    logic [1:0] sel4;
    logic       out4;

    int tests;
    int failed;

    mux_add u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in2),
        .sel   (sel2),
        .out   (out2)
    );

    mux_add #(
        .INUM    (4),
        .LOGINUM (2)
    ) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in4),
        .sel   (sel4),
        .out   (out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a registered mux outputs the selected bit of the previous cycle.
    function automatic logic ref_pick(input logic [31:0] vec, input int idx);
        return vec[idx];
    endfunction

    initial begin
        int          ones;
        logic        b;
        logic        exp_bit;
        logic        exp4;
        logic [1:0]  pat [40];
        logic        rec [40];
        tests  = 0;
        failed = 0;

        rst_n = 1'b0;
        in2   = 2'b01;
        sel2  = 1'b0;
        in4   = 4'b0000;
        sel4  = 2'd0;
        #1;
        check("reset_out_zero", {31'd0, out2}, 32'd0);
        step();
        check("reset_held_edge", {31'd0, out2}, 32'd0);

`ifdef MUX_ADD_LFSR_SEL_EN
        // Maximal-length 8-bit LFSR: over one period bit 0 is 0 in 127 states.
        rst_n = 1'b1;
        in2   = 2'b01;
        ones  = 0;
        for (int c = 0; c < 255; c++) begin
            sel2 = 1'($urandom);
            step();
            ones += int'(out2);
        end
        check("lfsr_ones_in_range", {31'd0, (ones >= 126 && ones <= 129)}, 32'd1);
        check("lfsr_not_constant", {31'd0, (ones > 0 && ones < 255)}, 32'd1);

        // Same input pattern from reset with sel=0 then random sel must match.
        for (int i = 0; i < 40; i++) pat[i] = 2'($urandom);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        sel2  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in2 = pat[i];
            step();
            rec[i] = out2;
        end
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in2  = pat[i];
            sel2 = 1'($urandom);
            step();
            check("lfsr_sel_ignored", {31'd0, out2}, {31'd0, rec[i]});
        end
        rst_n = 1'b0;
        #1;
        check("lfsr_async_reset", {31'd0, out2}, 32'd0);
`else
        rst_n = 1'b1;
        step();
        check("first_capture_after_release", {31'd0, out2}, 32'd1);

        sel2 = 1'b0;
        in2 = 2'b10; step(); check("s0_in10", {31'd0, out2}, 32'd0);
        in2 = 2'b11; step(); check("s0_in11", {31'd0, out2}, 32'd1);
        in2 = 2'b00; step(); check("s0_in00", {31'd0, out2}, 32'd0);

        sel2 = 1'b1;
        in2 = 2'b10; step(); check("s1_in10", {31'd0, out2}, 32'd1);
        in2 = 2'b01; step(); check("s1_in01", {31'd0, out2}, 32'd0);

        in2 = 2'b10;
        for (int i = 0; i < 8; i++) begin
            sel2    = 1'(i % 2);
            exp_bit = ref_pick({30'd0, in2}, int'(sel2));
            step();
            check("toggle_sel", {31'd0, out2}, {31'd0, exp_bit});
        end

        // Random traffic; unselected 2-input bit driven to X.
        for (int i = 0; i < 64; i++) begin
            b    = 1'($urandom);
            sel2 = 1'($urandom);
            in2  = (sel2 == 1'b0) ? {1'bx, b} : {b, 1'bx};
            in4  = 4'($urandom);
            sel4 = 2'($urandom);
            exp4 = ref_pick({28'd0, in4}, int'(sel4));
            step();
            check("rand_2in", {31'd0, out2}, {31'd0, b});
            check("rand_4in", {31'd0, out4}, {31'd0, exp4});
        end

        in2 = 2'b11; sel2 = 1'b0;
        step();
        check("pre_async_reset", {31'd0, out2}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_cycle", {31'd0, out2}, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("resume_after_reset", {31'd0, out2}, 32'd1);

        // Scaled add: only stream 0 is ones, uniform sel -> one quarter.
        in4  = 4'b0001;
        ones = 0;
        for (int c = 0; c < 400; c++) begin
            sel4 = 2'(c % 4);
            step();
            ones += int'(out4);
        end
        check("scaled_add_ones", ones, 32'd100);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
